// File: rtl/carry_select_subtractor_pipe.sv
// -----------------------------------------------------------------------------
// carry_select_subtractor_pipe
//   Two-stage pipelined borrow-select subtractor: diff = a - b - bin.
//   Stage 1 ripples the low block with the real borrow-in and precomputes both
//   borrow-in candidates for every upper block. Stage 2 resolves the borrow
//   chain, selects the candidates and registers diff/bout/ovf.
//   Both stages sit behind a valid/ready handshake with full-rate throughput.
//
// Parameters
//   WIDTH  operand width (multiple of BLOCK, >= 2*BLOCK)
//   BLOCK  bits per ripple block
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready is combinational)
//   a, b, bin             minuend, subtrahend, borrow-in
//   out_valid / out_ready result handshake
//   diff                  (a - b - bin) mod 2^WIDTH
//   bout                  1 iff unsigned a < b + bin
//   ovf                   signed overflow of the subtraction
// -----------------------------------------------------------------------------

// One ripple block: x - y - borrow_in done as x + ~y + ~borrow_in.
module css_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] x,
    input  logic [BLOCK-1:0] y,
    input  logic             borrow_in,
    output logic [BLOCK-1:0] d,
    output logic             borrow_out
);
    logic carry;

    assign {carry, d}  = {1'b0, x} + {1'b0, ~y} + {{BLOCK{1'b0}}, ~borrow_in};
    assign borrow_out  = ~carry;
endmodule

module carry_select_subtractor_pipe #(
    parameter int WIDTH = 8,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);
    localparam int NB = WIDTH / BLOCK;

    // Stage-1 contents: resolved low block plus both candidates per upper block.
    typedef struct packed {
        logic [BLOCK-1:0]          d_lo;
        logic                      b_lo;
        logic [NB-1:1][BLOCK-1:0]  d_c0;
        logic [NB-1:1][BLOCK-1:0]  d_c1;
        logic [NB-1:1]             b_c0;
        logic [NB-1:1]             b_c1;
        logic                      sa;
        logic                      sb;
    } s1_t;

    s1_t s1_next, s1;

    // vld_pipe[1] = stage-1 valid, vld_pipe[2] = stage-2 valid
    logic [2:1] vld_pipe;
    logic       s1_ready, s2_ready;

    // ---------------- stage 1 arithmetic ----------------
    logic [BLOCK-1:0]          lo_d;
    logic                      lo_b;
    logic [NB-1:1][BLOCK-1:0]  c0_d, c1_d;
    logic [NB-1:1]             c0_b, c1_b;

    css_block #(.BLOCK(BLOCK)) u_lo (
        .x(a[BLOCK-1:0]), .y(b[BLOCK-1:0]), .borrow_in(bin),
        .d(lo_d), .borrow_out(lo_b)
    );

    for (genvar k = 1; k < NB; k++) begin : g_blk
        css_block #(.BLOCK(BLOCK)) u_c0 (
            .x(a[k*BLOCK +: BLOCK]), .y(b[k*BLOCK +: BLOCK]), .borrow_in(1'b0),
            .d(c0_d[k]), .borrow_out(c0_b[k])
        );
        css_block #(.BLOCK(BLOCK)) u_c1 (
            .x(a[k*BLOCK +: BLOCK]), .y(b[k*BLOCK +: BLOCK]), .borrow_in(1'b1),
            .d(c1_d[k]), .borrow_out(c1_b[k])
        );
    end

    always_comb begin
        s1_next      = '0;
        s1_next.d_lo = lo_d;
        s1_next.b_lo = lo_b;
        s1_next.d_c0 = c0_d;
        s1_next.d_c1 = c1_d;
        s1_next.b_c0 = c0_b;
        s1_next.b_c1 = c1_b;
        s1_next.sa   = a[WIDTH-1];
        s1_next.sb   = b[WIDTH-1];
    end

    // ---------------- stage 2 selection ----------------
    // Borrow resolves block by block; each block's borrow picks the next one's pair.
    logic [NB-1:0]             sel_b;
    logic [NB-1:0][BLOCK-1:0]  sel_d;
    logic [WIDTH-1:0]          diff_sel;

    always_comb begin
        sel_b    = '0;
        sel_d    = '0;
        sel_b[0] = s1.b_lo;
        sel_d[0] = s1.d_lo;
        for (int k = 1; k < NB; k++) begin
            sel_d[k] = sel_b[k-1] ? s1.d_c1[k] : s1.d_c0[k];
            sel_b[k] = sel_b[k-1] ? s1.b_c1[k] : s1.b_c0[k];
        end
    end

    assign diff_sel = sel_d;

    // ---------------- handshake ----------------
    assign s2_ready  = !vld_pipe[2] || out_ready;
    assign s1_ready  = !vld_pipe[1] || s2_ready;
    assign in_ready  = s1_ready;
    assign out_valid = vld_pipe[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            s1       <= '0;
            diff     <= '0;
            bout     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            // s1_ready implies stage 1 is empty or draining, so valid simply follows in_valid.
            if (s1_ready) begin
                vld_pipe[1] <= in_valid;
                if (in_valid) s1 <= s1_next;
            end
            if (s2_ready) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    diff <= diff_sel;
                    bout <= sel_b[NB-1];
                    ovf  <= (s1.sa ^ s1.sb) & (diff_sel[WIDTH-1] ^ s1.sa);
                end
            end
        end
    end
endmodule
